uart_tx_ctrl: RTL
=================

// Module: uart_tx_ctrl
// PURPOSE
//  UART transmit serializer that sits directly downstream of the async FIFO read controller.
//  Pops one word whenever idle and the FIFO is non-empty, then shifts it out on tx_o.
//  Frame: start bit, data LSB first, optional parity, 1 or 2 stop bits.
//  Single clock domain: the FIFO read clock.
// PARAMETERS
//  DLY         1         simulation delay on all nonblocking assignments (#DLY)
//  FIFO_WIDTH  8         data bits per frame (5..9)
//  CLK_FREQ    50000000  clk_i frequency, Hz
//  BAUD_RATE   115200    line rate; DIV = CLK_FREQ/BAUD_RATE (integer divide); DIV>=2 is required
//  PARITY_EN   0         1 = append a parity bit after the data
//  PARITY_ODD  0         parity type when PARITY_EN=1: 0 = even, 1 = odd
//  STOP_BITS   1         number of stop bits, 1 or 2
// PORTS
//  clk_i       in   1           clock (same clock as FIFO read side)
//  rst_i       in   1           asynchronous reset, active-high
//  empty_i     in   1           FIFO empty flag
//  rd_valid_i  in   1           FIFO read accepted this cycle (= !empty_i && rd_en_o)
//  rd_vdata_i  in   FIFO_WIDTH  FIFO read data; valid in the same cycle as rd_valid_i
//  rd_en_o     out  1           pop request to the FIFO
//  tx_o        out  1           serial line; idles high
//  busy_o      out  1           high whenever state != IDLE
//  tx_done_o   out  1           one-cycle pulse after the last stop bit
// BEHAVIOUR
//  Reset values (asynchronous): state=IDLE, tx_o=1, busy_o=0, tx_done_o=0, shift register=0, counters=0.
//  rd_en_o: combinational, = (state==IDLE) && !empty_i && !rst_i. It is never high outside IDLE.
//  Capture: on a clock edge in IDLE with rd_valid_i=1:
//    shift register <= rd_vdata_i; parity <= ^rd_vdata_i ^ PARITY_ODD; state -> START.
//  States and transitions:
//    IDLE -> START -> DATA (FIFO_WIDTH bits) -> [PARITY] -> STOP (STOP_BITS bits) -> IDLE.
//  tx_o is registered:
//    Drops to 0 in the cycle after capture.
//    Each bit holds for exactly DIV cycles.
//  Baud counter: 0..DIV-1, cleared at capture. A bit ends when the counter reaches DIV-1.
//  Bit counter: counts DATA bits and stop bits. Its width is clog2(FIFO_WIDTH+1).
//  Frame length:
//    (1 + FIFO_WIDTH + PARITY_EN + STOP_BITS) * DIV cycles, measured from the first tx_o=0 cycle.
//  Frame end: on the final cycle of the last stop bit, state <= IDLE and tx_done_o <= 1 (registered).
//    tx_done_o is therefore high during the first IDLE cycle. In that same cycle rd_en_o may pop the next word.
//    The minimum gap between frames is 1 extra high cycle.
//  Boundary behaviour:
//    empty_i toggling while busy: ignored.
//    rd_valid_i outside IDLE: ignored (protocol violation; flagged by an assertion).
//    FIFO empty at frame end: stay in IDLE with tx_o=1.
//    rst_i mid-frame: tx_o returns to 1 immediately and the frame is abandoned. The popped word is lost. No tx_done_o.
//    rst_i released: rd_en_o can assert in the first clock after release.
// STRUCTURE
//  Shared include uart_pkg.vh:
//    state encodings ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP;
//    parity and stop-bit option constants;
//    DIV calculation macro.
//  Sub-module uart_baud_gen: DIV counter with synchronous clear and a bit_end tick output.
//    The same sub-module is reused by the future rx side.
//  Top level: FSM, shift register, bit counter, parity register, output registers.
// TESTING (bench: CLK_FREQ=16, BAUD_RATE=4 -> DIV=4, FIFO_WIDTH=8 unless stated)
//  1 Single byte: write 0x55 to FIFO.
//    -> rd_en_o high for 1 cycle.
//    -> tx_o = 0,1,0,1,0,1,0,1,0,1 (start, data, stop), 4 cycles per bit, 40 cycles total.
//    -> tx_done_o pulses once; busy_o falls with it.
//  2 Back-to-back: FIFO preloaded with 0xA3 and 0x0F.
//    -> second pop occurs in the tx_done_o cycle.
//    -> exactly 1 extra idle-high cycle between frames.
//    -> both frames bit-exact.
//  3 Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1.
//    Rerun with PARITY_ODD=1 -> parity bit 0. Frame is 44 cycles.
//  4 Two stop bits: STOP_BITS=2, byte 0xFF.
//    -> tx_o high for 8 cycles after the last data bit, before tx_done_o.
//  5 Reset mid-frame: assert rst_i during data bit 3 of 0x00.
//    -> tx_o=1 asynchronously, busy_o=0, no tx_done_o.
//    -> after release with FIFO non-empty, the next pop starts a clean frame.
//  6 Empty FIFO: hold empty_i=1 for 100 cycles.
//    -> rd_en_o=0, tx_o=1, busy_o=0 throughout.
//    -> a random empty_i glitch while busy causes no extra pop.

Source files
------------

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and helpers for the UART transmit path: FSM state encoding
// and the baud divider calculation.
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Clock cycles per serial bit; the caller guarantees the result is >= 2.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Bit-period counter: runs 0..DIV-1 and flags the last cycle of each bit.
// Held at zero while clr_i is high so a frame always starts on a fresh count.
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end_o = (r_cnt == LAST) && !clr_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit serializer fed by a FIFO read port: pops a word when idle,
// then sends start, data (LSB first), optional parity and 1..2 stop bits.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  empty_i,
    input  logic                  rd_valid_i,
    input  logic [FIFO_WIDTH-1:0] rd_vdata_i,
    output logic                  rd_en_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  tx_done_o
);

    localparam int            DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int            CW        = $clog2(FIFO_WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(FIFO_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
    localparam state_t        ST_AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

    state_t                  r_state,   w_state_nxt;
    logic [FIFO_WIDTH-1:0]   r_shift,   w_shift_nxt;
    logic [CW-1:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic                    r_parity,  w_parity_nxt;
    logic                    r_tx,      w_tx_nxt;
    logic                    r_done,    w_done_nxt;
    logic                    w_bit_end;
    logic                    w_baud_clr;

    // Counter is parked at zero in IDLE, which doubles as the clear at capture.
    assign w_baud_clr = (r_state == ST_IDLE);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_baud_clr),
        .bit_end_o (w_bit_end)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_parity  <= w_parity_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_parity_nxt  = r_parity;
        w_tx_nxt      = r_tx;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (rd_valid_i) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = rd_vdata_i;
                    w_parity_nxt  = (^rd_vdata_i) ^ 1'(PARITY_ODD);
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_DATA) begin
                        w_state_nxt   = ST_AFTER_DATA;
                        w_bit_cnt_nxt = '0;
                        w_tx_nxt      = (PARITY_EN != 0) ? r_parity : 1'b1;
                    end else begin
                        // r_shift[1] is the bit that becomes the LSB after this shift.
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_state_nxt   = ST_IDLE;
                        w_bit_cnt_nxt = '0;
                        w_done_nxt    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign rd_en_o   = (r_state == ST_IDLE) && !empty_i && !rst_i;
    assign tx_o      = r_tx;
    assign busy_o    = (r_state != ST_IDLE);
    assign tx_done_o = r_done;

    // A FIFO handshake while a frame is in flight means the upstream ignored rd_en_o.
    ap_valid_only_idle: assert property (
        @(posedge clk_i) disable iff (rst_i) rd_valid_i |-> (r_state == ST_IDLE)
    );

endmodule
